// File: rtl/gate_vector_sequencer_if.sv
// Stimulus/response bundle between the vector sequencer and its environment.
// The environment drives start and the gate output; the sequencer drives the rest.
interface gate_vector_sequencer_if;
    logic       start;
    logic       dut_out;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
    logic [1:0] vec_idx;

    modport master (
        output start,
        output dut_out,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec,
        input  vec_idx
    );

    modport slave (
        input  start,
        input  dut_out,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec,
        output vec_idx
    );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Sweeps a 2-input gate through all four input vectors, holds each one for
// HOLD_CYCLES cycles, samples the gate output and scores it against TRUTH_TABLE.
module gate_vector_sequencer #(
    parameter int unsigned HOLD_CYCLES = 3,
    parameter logic [3:0]  TRUTH_TABLE = 4'b1110
) (
    input logic clk,
    input logic rst_n,
    gate_vector_sequencer_if.slave bus
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      idx_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [2:0]      err_q;
    logic [3:0]      fail_q;

    logic            exp_bit;
    logic            mis;
    logic [2:0]      err_d;
    logic [3:0]      fail_d;

    // Case inequality so an X or Z from the gate is scored as a failure.
    assign exp_bit = TRUTH_TABLE[idx_q];
    assign mis     = (bus.dut_out !== exp_bit);
    assign err_d   = err_q + {2'b00, mis};
    assign fail_d  = fail_q | ({3'b000, mis} << idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= DRIVE;
                        cnt_q   <= '0;
                        idx_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= 3'd0;
                        fail_q  <= 4'd0;
                    end
                end
                DRIVE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        err_q  <= err_d;
                        fail_q <= fail_d;
                        cnt_q  <= '0;
                        if (idx_q != 2'd3) begin
                            idx_q <= idx_q + 2'd1;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 3'd0);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a         = idx_q[1];
    assign bus.b         = idx_q[0];
    assign bus.vec_idx   = idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
Self-checking stimulus and response stage for 2-input gate blocks. It drives the gate's a/b inputs through all four input combinations, holds each for a programmable number of cycles, then samples the gate output. Each sample is compared against a parameterised truth table. It sits directly upstream of the gate under test and also consumes the gate's output, replacing hand-written delay-based stimulus with a clocked, reusable checker.

Parameters:
HOLD_CYCLES, 3, cycles each vector is held before the output is sampled; legal range 1..255.
TRUTH_TABLE, 4'b1110, expected gate output; bit i is the expected output for {a,b}=i (the default is OR).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a sweep; honoured only in IDLE or DONE.
dut_out  input  1  output of the gate under test.
a  output  1  gate input a (registered).
b  output  1  gate input b (registered).
busy  output  1  high while a sweep is in progress.
done  output  1  level; high from sweep completion until the next start or reset.
pass  output  1  valid when done=1; 1 iff err_count==0.
err_count  output  3  number of mismatching vectors, 0..4.
fail_vec  output  4  bit i set if vector {a,b}=i mismatched.
vec_idx  output  2  index of the vector currently driven.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vec_idx=0, hold counter=0.
- Hold counter width is clog2(HOLD_CYCLES) with a minimum of 1 bit.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - Outputs hold their reset values.
  - start=1 at an edge -> DRIVE. At the same edge: vec_idx=0, {a,b}=2'b00, counter=0, busy=1, err_count=0, fail_vec=0.
- DRIVE:
  - {a,b}==vec_idx at all times. Counter increments each edge.
  - On the edge where counter==HOLD_CYCLES-1, dut_out is sampled and compared with TRUTH_TABLE[vec_idx] using 4-state inequality, so X or Z counts as a mismatch.
  - On a mismatch: err_count+1 and fail_vec[vec_idx]=1, both on that same edge.
  - On that same edge, if vec_idx<3: vec_idx+1, {a,b} updated, counter=0.
  - If vec_idx==3: go to DONE, busy=0, done=1, pass=(final err_count==0 including this vector's result). a, b and vec_idx hold at 3.
- DONE:
  - All results are held stable.
  - start=1 -> restart exactly as from IDLE: done=0, pass=0, results cleared, vector 0 applied on that edge.
- start is ignored while busy=1; no restart and no state change.
- Latency: if start is sampled at edge k, vector i is sampled at edge k+(i+1)*HOLD_CYCLES. done rises after edge k+4*HOLD_CYCLES. Each vector is driven for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: a new vector every cycle; the DUT must be combinational with zero latency.
- Reset mid-sweep: immediate return to IDLE with all outputs at reset values. No partial results are retained.
- err_count cannot wrap; its maximum value is 4.

Test Plan:
- Default params, dut_out driven by an OR model; pulse start -> done rises 12 cycles after the start edge, pass=1, err_count=0, fail_vec=0000. a/b sequence is 00,01,10,11, each held 3 cycles.
- Default params, dut_out driven by an AND model -> pass=0, err_count=2, fail_vec=0110.
- dut_out stuck at 0 -> err_count=3, fail_vec=1110. Then re-pulse start with an OR model -> results clear on the start edge, then pass=1, err_count=0.
- dut_out=X for vector 3 only, with an OR model otherwise -> err_count=1, fail_vec=1000, pass=0.
- Pulse start again at cycle 5 of a sweep -> ignored; done still rises at cycle 12. Assert rst_n=0 at cycle 7 of a new sweep -> busy=0, a=b=0, err_count=0 immediately, without waiting for a clock edge.
- HOLD_CYCLES=1 with an OR model -> vectors change every cycle; done rises 4 cycles after the start edge with pass=1.
